// File: rtl/vram_arbiter_pkg.sv
// rtl/vram_arbiter_pkg.sv - shared widths, owner encoding and tag type for the VRAM arbiter
package vram_arbiter_pkg;

    localparam int VRAM_AW_DEF  = 17;
    localparam int VRAM_DW_DEF  = 12;
    localparam int VRAM_SCW_DEF = 16;

    localparam logic OWN_DISP = 1'b0;
    localparam logic OWN_CPU  = 1'b1;

    // 640x480 at one word per pixel needs AW=19; the 17-bit default holds 320x240
    localparam int VRAM_DEPTH_640X480 = 307200;
    localparam int VRAM_DEPTH_320X240 = 76800;

    // Rides alongside each VRAM command so read data can be steered back
    typedef struct packed {
        logic valid;
        logic owner;
        logic is_read;
    } vram_tag_t;

    localparam vram_tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_DISP, is_read: 1'b0};

endpackage

// File: rtl/vram_cpu_hold.sv
// rtl/vram_cpu_hold.sv - one-entry CPU holding register with EMPTY/FULL FSM and stall counter
module vram_cpu_hold
    import vram_arbiter_pkg::*;
#(
    parameter int AW  = VRAM_AW_DEF,
    parameter int DW  = VRAM_DW_DEF,
    parameter int SCW = VRAM_SCW_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           DISP_REQ,
    input  logic           CPU_REQ,
    input  logic           CPU_WE,
    input  logic [AW-1:0]  CPU_ADDR,
    input  logic [DW-1:0]  CPU_WDATA,
    output logic           CPU_ACK,
    output logic           HOLD_ISSUE,
    output logic           HOLD_WE,
    output logic [AW-1:0]  HOLD_ADDR,
    output logic [DW-1:0]  HOLD_WDATA,
    output logic [SCW-1:0] STALL_CNT
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0] state;
    logic       capture;

    // Accept whenever the slot is free or is being drained this cycle
    always_comb begin
        CPU_ACK    = (state == ST_EMPTY) || !DISP_REQ;
        HOLD_ISSUE = (state == ST_FULL) && !DISP_REQ;
        capture    = CPU_REQ && CPU_ACK;
    end

    // Slot occupancy: a new capture wins over the drain so back-to-back ops stay FULL
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_EMPTY;
        end else if (capture) begin
            state <= ST_FULL;
        end else if (HOLD_ISSUE) begin
            state <= ST_EMPTY;
        end
    end

    // Held operation payload
    always_ff @(posedge CLK) begin
        if (RST) begin
            HOLD_WE    <= 1'b0;
            HOLD_ADDR  <= '0;
            HOLD_WDATA <= '0;
        end else if (capture) begin
            HOLD_WE    <= CPU_WE;
            HOLD_ADDR  <= CPU_ADDR;
            HOLD_WDATA <= CPU_WDATA;
        end
    end

    // Count cycles a held op lost to the display, sticking at all-ones
    always_ff @(posedge CLK) begin
        if (RST) begin
            STALL_CNT <= '0;
        end else if ((state == ST_FULL) && DISP_REQ && (STALL_CNT != {SCW{1'b1}})) begin
            STALL_CNT <= STALL_CNT + 1'b1;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - display-priority arbiter for a single-port synchronous-read VRAM
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int AW  = VRAM_AW_DEF,
    parameter int DW  = VRAM_DW_DEF,
    parameter int SCW = VRAM_SCW_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           DISP_REQ,
    input  logic [AW-1:0]  DISP_ADDR,
    output logic [DW-1:0]  DISP_DATA,
    output logic           DISP_VALID,
    input  logic           CPU_REQ,
    input  logic           CPU_WE,
    input  logic [AW-1:0]  CPU_ADDR,
    input  logic [DW-1:0]  CPU_WDATA,
    output logic           CPU_ACK,
    output logic [DW-1:0]  CPU_RDATA,
    output logic           CPU_RVALID,
    output logic           MEM_EN,
    output logic           MEM_WE,
    output logic [AW-1:0]  MEM_ADDR,
    output logic [DW-1:0]  MEM_WDATA,
    input  logic [DW-1:0]  MEM_RDATA,
    output logic [SCW-1:0] STALL_CNT
);

    logic          hold_issue;
    logic          hold_we;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_wdata;
    vram_tag_t     tag_cmd;
    vram_tag_t     tag_mem;

    vram_cpu_hold #(
        .AW  (AW),
        .DW  (DW),
        .SCW (SCW)
    ) u_hold (
        .CLK        (CLK),
        .RST        (RST),
        .DISP_REQ   (DISP_REQ),
        .CPU_REQ    (CPU_REQ),
        .CPU_WE     (CPU_WE),
        .CPU_ADDR   (CPU_ADDR),
        .CPU_WDATA  (CPU_WDATA),
        .CPU_ACK    (CPU_ACK),
        .HOLD_ISSUE (hold_issue),
        .HOLD_WE    (hold_we),
        .HOLD_ADDR  (hold_addr),
        .HOLD_WDATA (hold_wdata),
        .STALL_CNT  (STALL_CNT)
    );

    // Command register: display first, then the held CPU op, else idle
    always_ff @(posedge CLK) begin
        if (RST) begin
            MEM_EN    <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            tag_cmd   <= TAG_IDLE;
        end else if (DISP_REQ) begin
            MEM_EN    <= 1'b1;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= DISP_ADDR;
            tag_cmd   <= '{valid: 1'b1, owner: OWN_DISP, is_read: 1'b1};
        end else if (hold_issue) begin
            MEM_EN    <= 1'b1;
            MEM_WE    <= hold_we;
            MEM_ADDR  <= hold_addr;
            MEM_WDATA <= hold_wdata;
            tag_cmd   <= '{valid: 1'b1, owner: OWN_CPU, is_read: !hold_we};
        end else begin
            MEM_EN    <= 1'b0;
            MEM_WE    <= 1'b0;
            tag_cmd   <= TAG_IDLE;
        end
    end

    // Second tag stage lines up with MEM_RDATA arriving from the VRAM
    always_ff @(posedge CLK) begin
        if (RST) begin
            tag_mem <= TAG_IDLE;
        end else begin
            tag_mem <= tag_cmd;
        end
    end

    // Steer read data to its owner; only one tag per cycle so VALIDs are exclusive
    always_ff @(posedge CLK) begin
        if (RST) begin
            DISP_VALID <= 1'b0;
            DISP_DATA  <= '0;
            CPU_RVALID <= 1'b0;
            CPU_RDATA  <= '0;
        end else begin
            DISP_VALID <= tag_mem.valid && tag_mem.is_read && (tag_mem.owner == OWN_DISP);
            CPU_RVALID <= tag_mem.valid && tag_mem.is_read && (tag_mem.owner == OWN_CPU);
            if (tag_mem.valid && tag_mem.is_read && (tag_mem.owner == OWN_DISP)) begin
                DISP_DATA <= MEM_RDATA;
            end
            if (tag_mem.valid && tag_mem.is_read && (tag_mem.owner == OWN_CPU)) begin
                CPU_RDATA <= MEM_RDATA;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - randomized scoreboard bench for vram_arbiter
module tb_vram_arbiter;
    import vram_arbiter_pkg::*;

    localparam int AW  = 17;
    localparam int DW  = 12;
    localparam int SCW = 16;

    logic           CLK = 1'b0;
    logic           RST;
    logic           DISP_REQ;
    logic [AW-1:0]  DISP_ADDR;
    logic [DW-1:0]  DISP_DATA;
    logic           DISP_VALID;
    logic           CPU_REQ;
    logic           CPU_WE;
    logic [AW-1:0]  CPU_ADDR;
    logic [DW-1:0]  CPU_WDATA;
    logic           CPU_ACK;
    logic [DW-1:0]  CPU_RDATA;
    logic           CPU_RVALID;
    logic           MEM_EN;
    logic           MEM_WE;
    logic [AW-1:0]  MEM_ADDR;
    logic [DW-1:0]  MEM_WDATA;
    logic [DW-1:0]  MEM_RDATA;
    logic [SCW-1:0] STALL_CNT;

    logic [DW-1:0]  s_disp_data;
    logic           s_disp_valid;
    logic           s_cpu_ack;
    logic [DW-1:0]  s_cpu_rdata;
    logic           s_cpu_rvalid;
    logic           s_mem_en;
    logic           s_mem_we;
    logic [AW-1:0]  s_mem_addr;
    logic [DW-1:0]  s_mem_wdata;
    logic [3:0]     s_stall_cnt;

    always #5 CLK = ~CLK;

    vram_arbiter #(.AW(AW), .DW(DW), .SCW(SCW)) dut (
        .CLK(CLK), .RST(RST),
        .DISP_REQ(DISP_REQ), .DISP_ADDR(DISP_ADDR), .DISP_DATA(DISP_DATA), .DISP_VALID(DISP_VALID),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA), .CPU_RVALID(CPU_RVALID),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA), .STALL_CNT(STALL_CNT)
    );

    // Narrow stall counter copy, fed the same stimulus, to see saturation
    vram_arbiter #(.AW(AW), .DW(DW), .SCW(4)) u_sat (
        .CLK(CLK), .RST(RST),
        .DISP_REQ(DISP_REQ), .DISP_ADDR(DISP_ADDR), .DISP_DATA(s_disp_data), .DISP_VALID(s_disp_valid),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_ACK(s_cpu_ack), .CPU_RDATA(s_cpu_rdata), .CPU_RVALID(s_cpu_rvalid),
        .MEM_EN(s_mem_en), .MEM_WE(s_mem_we), .MEM_ADDR(s_mem_addr), .MEM_WDATA(s_mem_wdata),
        .MEM_RDATA(MEM_RDATA), .STALL_CNT(s_stall_cnt)
    );

    // Synchronous-read VRAM environment
    logic [DW-1:0] vmem [0:(1<<AW)-1];
    always @(posedge CLK) begin
        if (MEM_EN) begin
            if (MEM_WE) vmem[MEM_ADDR] <= MEM_WDATA;
            else        MEM_RDATA <= vmem[MEM_ADDR];
        end
    end

    // Reference model state
    typedef struct {
        int            cyc;
        bit            owner;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } op_t;

    exp_t          sb[$];
    op_t           held[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int unsigned   m_stall = 0;
    int unsigned   exp_stall = 0;
    bit            exp_ack = 1'b1;
    bit            check_en = 1'b0;
    bit            starving = 1'b0;
    int            we_count = 0;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cyc, got, exp);
        end
    endtask

    // One clock of stimulus; the model applies the arbitration rules to the same inputs
    task automatic step(input bit rst, input bit dreq, input logic [AW-1:0] daddr,
                        input bit creq, input bit we, input logic [AW-1:0] caddr,
                        input logic [DW-1:0] wd);
        op_t  op;
        exp_t e;
        @(posedge CLK);
        #1;
        RST       = rst;
        DISP_REQ  = dreq;
        DISP_ADDR = daddr;
        CPU_REQ   = creq;
        CPU_WE    = we;
        CPU_ADDR  = caddr;
        CPU_WDATA = wd;
        exp_stall = m_stall;
        exp_ack   = (held.size() == 0) || !dreq;
        check_en  = 1'b1;
        if (rst) begin
            while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
            held.delete();
            m_stall = 0;
        end else begin
            if (dreq) begin
                e.cyc = cyc + 3; e.owner = OWN_DISP; e.data = ref_mem[daddr];
                sb.push_back(e);
                if (held.size() > 0 && m_stall < 65535) m_stall++;
            end else if (held.size() > 0) begin
                op = held.pop_front();
                if (op.we) begin
                    ref_mem[op.addr] = op.wdata;
                end else begin
                    e.cyc = cyc + 3; e.owner = OWN_CPU; e.data = ref_mem[op.addr];
                    sb.push_back(e);
                end
            end
            if (creq && exp_ack) begin
                op.we = we; op.addr = caddr; op.wdata = wd;
                held.push_back(op);
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_en"},     {31'd0, MEM_EN},     32'd0);
        chk({tag, "_mem_we"},     {31'd0, MEM_WE},     32'd0);
        chk({tag, "_mem_addr"},   {15'd0, MEM_ADDR},   32'd0);
        chk({tag, "_mem_wdata"},  {20'd0, MEM_WDATA},  32'd0);
        chk({tag, "_disp_valid"}, {31'd0, DISP_VALID}, 32'd0);
        chk({tag, "_disp_data"},  {20'd0, DISP_DATA},  32'd0);
        chk({tag, "_cpu_rvalid"}, {31'd0, CPU_RVALID}, 32'd0);
        chk({tag, "_cpu_rdata"},  {20'd0, CPU_RDATA},  32'd0);
        chk({tag, "_stall"},      {16'd0, STALL_CNT},  32'd0);
        chk({tag, "_ack_empty"},  {31'd0, CPU_ACK},    32'd1);
    endtask

    // Monitor: per-cycle ACK/stall checks and scoreboard pops on every VALID
    always @(negedge CLK) begin
        exp_t e;
        if (check_en) begin
            chk("cpu_ack", {31'd0, CPU_ACK}, {31'd0, exp_ack});
            chk("stall_cnt", {16'd0, STALL_CNT}, exp_stall);
            chk("stall_sat", {28'd0, s_stall_cnt}, (exp_stall > 15) ? 32'd15 : exp_stall);
            if (DISP_VALID && CPU_RVALID) chk("double_valid", 32'd1, 32'd0);
            if (DISP_VALID || CPU_RVALID) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", {31'd0, CPU_RVALID}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_owner", {31'd0, CPU_RVALID}, {31'd0, e.owner});
                    chk("rsp_cycle", cyc, e.cyc);
                    chk("rsp_data", {20'd0, (CPU_RVALID ? CPU_RDATA : DISP_DATA)}, {20'd0, e.data});
                end
            end
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                chk("missing_rsp_cycle", cyc, e.cyc);
            end
            if (starving && MEM_EN && MEM_WE) we_count++;
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            vmem[i]    = DW'(i * 3);
            ref_mem[i] = DW'(i * 3);
        end
        RST = 1'b1; DISP_REQ = 1'b0; DISP_ADDR = '0;
        CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_WDATA = '0;
        repeat (3) @(posedge CLK);

        // Reset state
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        idle();
        chk_all_zero("reset");

        // Display-only scan of 0..7, expecting a*3 back to back
        for (int a = 0; a < 8; a++) step(1'b0, 1'b1, AW'(a), 1'b0, 1'b0, '0, '0);
        repeat (5) idle();

        // CPU write then read of the same address
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 17'h100, 12'h5A5);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 17'h100, '0);
        repeat (6) idle();

        // Reset mid-traffic: CPU read accepted, issued, then reset
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 17'h20, '0);
        idle();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        idle();
        chk_all_zero("midreset");
        repeat (4) idle();

        // Starvation: accepted while display busy, then 640 blocked cycles
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        starving = 1'b1;
        step(1'b0, 1'b1, 17'h0, 1'b1, 1'b1, 17'h55, 12'hABC);
        for (int i = 0; i < 640; i++)
            step(1'b0, 1'b1, AW'(i), 1'b1, 1'($urandom), AW'($urandom_range(0, 63)), DW'($urandom));
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge CLK);
        #1 starving = 1'b0;
        idle();
        chk("starve_no_we", we_count, 32'd0);
        chk("starve_stall", {16'd0, STALL_CNT}, 32'd640);
        chk("starve_sat", {28'd0, s_stall_cnt}, 32'd15);
        chk("starve_issue_we", {31'd0, MEM_WE}, 32'd1);
        chk("starve_issue_addr", {15'd0, MEM_ADDR}, 32'h55);
        chk("starve_issue_data", {20'd0, MEM_WDATA}, 32'hABC);
        repeat (4) idle();

        // Interleave: display every other cycle, continuous CPU reads
        for (int i = 0; i < 60; i++)
            step(1'b0, (i % 2) == 0, AW'($urandom_range(0, 255)), 1'b1, 1'b0,
                 AW'($urandom_range(0, 255)), '0);
        repeat (5) idle();

        // Random traffic with occasional resets
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 63)),
                 $urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom_range(0, 63)), DW'($urandom));
        repeat (8) idle();
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
